// File: rtl/pck_socket_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pck_socket_arbiter
// Purpose  : Round-robin arbiter that admits one complete frame at a time from
//            N_SRC upstream sockets. It pops FRAME_LEN words from the winner and
//            forwards them, tagged with the source index, to one module-side
//            output.
// Revision : 1.0 - initial release
// ============================================================================
module pck_socket_arbiter #(
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 16,
  localparam int TAG_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                        clk,
  input  logic                        rst,        // asynchronous, active-low
  input  logic [N_SRC-1:0]            src_full,
  input  logic [N_SRC-1:0]            src_dv,
  input  logic [N_SRC*DATA_WIDTH-1:0] src_data,
  output logic [N_SRC-1:0]            src_rd_en,
  input  logic                        out_empty,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_dv,
  output logic [TAG_W-1:0]            out_tag,
  output logic                        out_sof,
  output logic                        out_eof,
  output logic                        busy
);

  localparam int               CNT_W      = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] C_LAST     = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] C_FULL     = CNT_W'(FRAME_LEN);
  localparam logic [TAG_W-1:0] C_LAST_SRC = TAG_W'(N_SRC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [TAG_W-1:0]      r_grant;
  logic [TAG_W-1:0]      r_last_grant;
  logic [TAG_W-1:0]      w_winner;
  logic [TAG_W-1:0]      w_scan_idx;
  logic                  w_found;
  logic                  w_start;
  logic                  w_dv;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [CNT_W-1:0]      r_rd_cnt;
  logic [CNT_W-1:0]      r_dv_cnt;

  // Round-robin search: first full socket after the last grant, wrapping; the
  // last grant itself is considered last so a lone requester is still served.
  always_comb begin
    w_found    = 1'b0;
    w_winner   = r_last_grant;
    w_scan_idx = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      w_scan_idx = TAG_W'((int'(r_last_grant) + k) % N_SRC);
      if (!w_found && src_full[w_scan_idx]) begin
        w_found  = 1'b1;
        w_winner = w_scan_idx;
      end
    end
  end

  // Select the granted socket's data word.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_grant == TAG_W'(i)) w_sel_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // A frame is committed only from IDLE; stray or surplus dv is never accepted.
  assign w_start = (r_state == ST_IDLE) && out_empty && w_found;
  assign w_dv    = src_dv[r_grant] && (r_state != ST_IDLE) && (r_dv_cnt != C_FULL);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; pop strobes decode from registered state and grant only.
  always_comb begin
    w_state_nxt = r_state;
    src_rd_en   = '0;
    busy        = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = ST_READ;
      end
      ST_READ: begin
        src_rd_en[r_grant] = 1'b1;
        if (r_rd_cnt == C_LAST) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_dv_cnt == C_FULL) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Grant bookkeeping and pop/arrival counters, cleared on entry to READ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant      <= '0;
      r_last_grant <= C_LAST_SRC;
      r_rd_cnt     <= '0;
      r_dv_cnt     <= '0;
    end else if (w_start) begin
      r_grant      <= w_winner;
      r_last_grant <= w_winner;
      r_rd_cnt     <= '0;
      r_dv_cnt     <= '0;
    end else begin
      if (r_state == ST_READ) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
      if (w_dv)               r_dv_cnt <= r_dv_cnt + CNT_W'(1);
    end
  end

  // Single forwarding register stage toward the module.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_dv   <= 1'b0;
      out_data <= '0;
      out_tag  <= '0;
      out_sof  <= 1'b0;
      out_eof  <= 1'b0;
    end else begin
      out_dv   <= w_dv;
      out_data <= w_sel_data;
      out_tag  <= r_grant;
      out_sof  <= w_dv && (r_dv_cnt == '0);
      out_eof  <= w_dv && (r_dv_cnt == C_LAST);
    end
  end

endmodule
`default_nettype wire

// File: doc/pck_socket_arbiter.md
# pck_socket_arbiter

Round-robin arbiter that shares one processing module's input between N_SRC upstream sockets in the PCK chain. It watches each socket's frame-ready (`full`) flag and grants one socket at a time. It pops exactly FRAME_LEN words from the granted socket and forwards them, tagged with the source index, to a single module-side output. A frame is admitted only when the downstream socket reports room (`empty`).

## Interface
- N_SRC, 4: number of upstream sockets (≥2)
- DATA_WIDTH, 8: word width
- FRAME_LEN, 16: words per frame (≥1)
- TAG_W, $clog2(N_SRC): source tag width (derived, not overridden)

Ports:
- clk  in  1  system clock; single clock domain, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- src_full  in  N_SRC  socket i holds ≥1 complete frame
- src_dv  in  N_SRC  socket i read data valid
- src_data  in  N_SRC*DATA_WIDTH  packed; socket i at [i*DATA_WIDTH +: DATA_WIDTH]
- src_rd_en  out  N_SRC  pop strobe to socket i; one word per cycle asserted
- out_empty  in  1  downstream socket can accept a full frame
- out_data  out  DATA_WIDTH  forwarded word
- out_dv  out  1  out_data valid
- out_tag  out  TAG_W  index of source socket for current word
- out_sof / out_eof  out  1 each  first / last word of frame (both high if FRAME_LEN=1)
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM has three states: IDLE, READ, DRAIN.
- IDLE: if out_empty=1 and any src_full=1, pick a winner and go to READ.
  - Winner is the first set src_full bit searching from (last_grant+1) mod N_SRC upward, with wrap.
  - Register the winner as grant; last_grant ← grant.
  - Otherwise stay in IDLE.
- READ:
  - src_rd_en[grant]=1 and all other bits 0.
  - rd_cnt counts 0..FRAME_LEN-1; after FRAME_LEN cycles go to DRAIN.
  - src_rd_en is decoded from registered state and grant only.
- DRAIN: wait until dv_cnt = FRAME_LEN, then go to IDLE.
- dv_cnt counts src_dv[grant] pulses while state ≠ IDLE. Counting overlaps READ.
- Forwarding is one register stage:
  - out_dv ← src_dv[grant] & (state≠IDLE)
  - out_data ← src_data[grant]
  - out_tag ← grant
  - out_sof ← (dv_cnt=0)
  - out_eof ← (dv_cnt=FRAME_LEN-1)
- src_dv on non-granted sockets, or any src_dv while in IDLE, is ignored. It is never forwarded and never counted.
- out_empty and src_full are sampled only in IDLE. Deassertion mid-frame does not abort or stall the frame; a committed frame always completes.
- No src_rd_en is ever issued beyond FRAME_LEN per grant.
- Counter widths are $clog2(FRAME_LEN+1). Counters clear on entry to READ.

## Timing
- Reset (rst=0, async) forces:
  - state=IDLE
  - src_rd_en=0, out_dv=0, out_data=0, out_tag=0, out_sof=0, out_eof=0, busy=0
  - rd_cnt=dv_cnt=0
  - last_grant=N_SRC-1, so socket 0 has first priority
- Reset asserted mid-frame abandons the frame immediately; nothing resumes after release.
- Request sampled in IDLE at cycle 0:
  - grant and busy valid at cycle 1
  - src_rd_en[grant] high for cycles 1..FRAME_LEN
  - socket returns src_dv at cycles 2..FRAME_LEN+1 (1-cycle read latency)
  - out_dv high at cycles 3..FRAME_LEN+2
  - FSM enters IDLE at FRAME_LEN+3; next arbitration is sampled in that cycle
- Throughput is FRAME_LEN words per FRAME_LEN+3 cycles.
- If the socket inserts gaps in dv, DRAIN extends until all FRAME_LEN words arrive. There is no timeout.
- Simultaneous requests are served strictly round-robin. No socket waits more than N_SRC-1 frames while its src_full stays high.

## Test plan
- Single source: rst released, src_full=0100, out_empty=1, FRAME_LEN=16, data 0x00..0x0F:
  - src_rd_en=0100 for cycles 1..16
  - out_dv cycles 3..18 carrying 0x00..0x0F, tag=2
  - sof on 0x00, eof on 0x0F
  - busy falls at cycle 19
- All sources full continuously: grant order 0,1,2,3,0…; each frame has exactly 16 rd_en pulses; no rd_en overlap between sockets.
- out_empty=0 with src_full=1111: stays IDLE, src_rd_en=0, busy=0. Drop out_empty mid-frame: the frame still completes all 16 words.
- Gapped source with dv every other cycle: DRAIN holds until the 16th dv; out_eof is on the 16th forwarded word; no extra rd_en is issued.
- Stray src_dv on a non-granted socket during a frame, and in IDLE: out_dv is unaffected and the word count is unchanged.
- rst pulsed low at word 7 of a frame: all outputs 0 asynchronously. After release with src_full=1111, the first grant is socket 0 and the frame is complete, with 16 words and sof/eof correct.
